snoop_responder: RTL and testbench

SNOOP_RESPONDER -- requirements
Module: snoop_responder

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/snoop_tag_match.sv | 35 +++
 rtl/snoop_responder.sv | 190 +++++++++++++++++++
 tb/tb_snoop_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the dcache snoop path: responder state encoding and
// snooped-address field layout.
package cpu_types_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned BLKOFF_BIT = 2;
    localparam int unsigned IDX_LSB    = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB0    = 3'd2,
        WB1    = 3'd3,
        UPDATE = 3'd4,
        DONE   = 3'd5
    } snoop_state_t;

    // Tag occupies everything above the set index.
    function automatic int unsigned tag_width(input int unsigned idx_w);
        return WORD_W - IDX_LSB - idx_w;
    endfunction

endpackage

// File: rtl/snoop_tag_match.sv
// Two-way tag compare for the snooped set; way 0 wins when both ways hit.
module snoop_tag_match #(
    parameter int unsigned TAG_W = 26,
    parameter int unsigned WAYS  = 2
) (
    input  logic [TAG_W-1:0]            tag,
    input  logic [WAYS-1:0][TAG_W-1:0]  way_tag,
    input  logic [WAYS-1:0]             way_valid,
    input  logic [WAYS-1:0]             way_dirty,
    output logic                        hit,
    output logic                        hit_way,
    output logic                        hit_dirty
);

    // Priority compare, way 0 first.
    always_comb begin
        hit       = 1'b0;
        hit_way   = 1'b0;
        hit_dirty = 1'b0;
        if (way_valid[0] && (way_tag[0] == tag)) begin
            hit       = 1'b1;
            hit_way   = 1'b0;
            hit_dirty = way_dirty[0];
        end else if (way_valid[1] && (way_tag[1] == tag)) begin
            hit       = 1'b1;
            hit_way   = 1'b1;
            hit_dirty = way_dirty[1];
        end else begin
            hit       = 1'b0;
            hit_way   = 1'b0;
            hit_dirty = 1'b0;
        end
    end

endmodule

// File: rtl/snoop_responder.sv
// Dcache snoop responder: looks up a snooped block, writes back a dirty copy
// over the dcache bus port, then downgrades or invalidates the frame.
module snoop_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned WAYS  = 2,
    localparam int unsigned TAG_W = tag_width(IDX_W)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        ccwait,
    input  logic                        ccinv,
    input  logic [31:0]                 ccsnoopaddr,
    input  logic                        dwait,
    input  logic                        cache_idle,
    input  logic [WAYS-1:0][TAG_W-1:0]  way_tag,
    input  logic [WAYS-1:0]             way_valid,
    input  logic [WAYS-1:0]             way_dirty,
    input  logic [31:0]                 rd_data,
    output logic [IDX_W-1:0]            snoop_idx,
    output logic                        rd_way,
    output logic                        rd_blkoff,
    output logic                        upd_en,
    output logic                        upd_way,
    output logic                        upd_valid,
    output logic                        upd_dirty,
    output logic                        ccwrite,
    output logic                        cctrans,
    output logic                        snoop_active,
    output logic                        dWEN,
    output logic [31:0]                 daddr,
    output logic [31:0]                 dstore
);

    snoop_state_t       state_r;
    snoop_state_t       state_next_s;
    logic [TAG_W-1:0]   tag_r;
    logic [IDX_W-1:0]   idx_r;
    logic               inv_r;
    logic               hit_r;
    logic               hit_way_r;
    logic               dirty_r;
    logic               cctrans_r;
    logic               match_hit_s;
    logic               match_way_s;
    logic               match_dirty_s;
    logic               accept_s;
    logic               addr_unused_s;

    // Block offset and byte bits are regenerated per writeback word.
    assign addr_unused_s = ^ccsnoopaddr[IDX_LSB-1:0];
    assign accept_s      = (state_r == IDLE) && ccwait && cache_idle;
    assign cctrans       = cctrans_r;

    snoop_tag_match #(
        .TAG_W (TAG_W),
        .WAYS  (WAYS)
    ) u_tag_match (
        .tag       (tag_r),
        .way_tag   (way_tag),
        .way_valid (way_valid),
        .way_dirty (way_dirty),
        .hit       (match_hit_s),
        .hit_way   (match_way_s),
        .hit_dirty (match_dirty_s)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Snoop request capture and registered lookup result.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tag_r     <= {TAG_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            inv_r     <= 1'b0;
            hit_r     <= 1'b0;
            hit_way_r <= 1'b0;
            dirty_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                tag_r <= ccsnoopaddr[WORD_W-1 -: TAG_W];
                idx_r <= ccsnoopaddr[IDX_LSB +: IDX_W];
                inv_r <= ccinv;
            end
            if (state_r == LOOKUP) begin
                hit_r     <= match_hit_s;
                hit_way_r <= match_way_s;
                dirty_r   <= match_dirty_s;
            end
        end
    end

    // One-cycle pulse following every state change.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cctrans_r <= 1'b0;
        end else begin
            cctrans_r <= (state_next_s != state_r);
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next_s = state_r;
        snoop_idx    = {IDX_W{1'b0}};
        rd_way       = 1'b0;
        rd_blkoff    = 1'b0;
        upd_en       = 1'b0;
        upd_way      = 1'b0;
        upd_valid    = 1'b0;
        upd_dirty    = 1'b0;
        ccwrite      = 1'b0;
        snoop_active = 1'b0;
        dWEN         = 1'b0;
        daddr        = 32'h0000_0000;
        dstore       = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (ccwait && cache_idle) begin
                    state_next_s = LOOKUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOOKUP: begin
                snoop_active = 1'b1;
                snoop_idx    = idx_r;
                if (match_hit_s && match_dirty_s) begin
                    state_next_s = WB0;
                end else if (match_hit_s) begin
                    state_next_s = UPDATE;
                end else begin
                    state_next_s = DONE;
                end
            end
            WB0, WB1: begin
                snoop_active = 1'b1;
                snoop_idx    = idx_r;
                ccwrite      = 1'b1;
                dWEN         = dirty_r;
                rd_way       = hit_way_r;
                rd_blkoff    = (state_r == WB1);
                daddr        = {tag_r, idx_r, (state_r == WB1), 2'b00};
                dstore       = rd_data;
                if (!ccwait) begin
                    state_next_s = IDLE;
                end else if (dirty_r && !dwait) begin
                    state_next_s = (state_r == WB0) ? WB1 : UPDATE;
                end else begin
                    state_next_s = state_r;
                end
            end
            UPDATE: begin
                snoop_active = 1'b1;
                snoop_idx    = idx_r;
                // A clean hit that is not invalidated already has the target state.
                if (hit_r && (dirty_r || inv_r)) begin
                    upd_en    = 1'b1;
                    upd_way   = hit_way_r;
                    upd_valid = ~inv_r;
                    upd_dirty = 1'b0;
                end else begin
                    upd_en    = 1'b0;
                end
                state_next_s = DONE;
            end
            DONE: begin
                snoop_active = 1'b1;
                snoop_idx    = idx_r;
                if (!ccwait) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Randomized scoreboard bench for snoop_responder: a frame model answers the
// lookups, a reference model predicts writeback words and frame updates.
module tb_snoop_responder;

    localparam int IDX_W = 3;
    localparam int TAG_W = 26;

    typedef struct {
        bit          is_upd;
        logic [31:0] addr;
        logic [31:0] data;
        bit          way;
        bit          valid;
    } exp_t;

    logic                     CLK;
    logic                     nRST;
    logic                     ccwait, ccinv, dwait, cache_idle;
    logic [31:0]              ccsnoopaddr;
    logic [1:0][TAG_W-1:0]    way_tag;
    logic [1:0]               way_valid, way_dirty;
    logic [31:0]              rd_data;
    logic [IDX_W-1:0]         snoop_idx;
    logic                     rd_way, rd_blkoff, upd_en, upd_way, upd_valid, upd_dirty;
    logic                     ccwrite, cctrans, snoop_active, dWEN;
    logic [31:0]              daddr, dstore;

    logic [TAG_W-1:0] tag_m   [2][8];
    bit               valid_m [2][8];
    bit               dirty_m [2][8];
    logic [31:0]      data_m  [2][8][2];

    exp_t             q[$];
    int               total = 0;
    int               bad = 0;
    logic [IDX_W-1:0] cur_idx = 3'd0;
    int               dwait_mode = 0;
    int               stall_cnt = 0;

    snoop_responder #(.IDX_W(IDX_W), .WAYS(2)) dut (
        .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .cache_idle(cache_idle),
        .way_tag(way_tag), .way_valid(way_valid), .way_dirty(way_dirty),
        .rd_data(rd_data), .snoop_idx(snoop_idx), .rd_way(rd_way),
        .rd_blkoff(rd_blkoff), .upd_en(upd_en), .upd_way(upd_way),
        .upd_valid(upd_valid), .upd_dirty(upd_dirty), .ccwrite(ccwrite),
        .cctrans(cctrans), .snoop_active(snoop_active), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Frame model answering the lookup/read ports
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_tag[w]   = tag_m[w][snoop_idx];
            way_valid[w] = valid_m[w][snoop_idx];
            way_dirty[w] = dirty_m[w][snoop_idx];
        end
        rd_data = data_m[rd_way][snoop_idx][rd_blkoff];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Bus stall generator: 0 none, 1 random, 2 always, 3 two stalls per word, 4 stall second word
    always @(posedge CLK) begin
        #1;
        case (dwait_mode)
            0: dwait = 1'b0;
            1: dwait = ($urandom_range(0, 2) == 0);
            2: dwait = 1'b1;
            3: begin
                if (dWEN) begin
                    dwait = (stall_cnt < 2);
                    stall_cnt = dwait ? stall_cnt + 1 : 0;
                end else begin
                    dwait = 1'b0;
                    stall_cnt = 0;
                end
            end
            default: dwait = dWEN & daddr[2];
        endcase
    end

    // Monitor: pops the scoreboard whenever a word or frame update is presented
    always @(negedge CLK) begin
        exp_t e;
        if (nRST) begin
            chk("ccwrite_vs_dwen", 32'(ccwrite), 32'(dWEN));
            if (snoop_active) chk("snoop_idx", 32'(snoop_idx), 32'(cur_idx));
            else chk("idle_quiet", 32'({dWEN, upd_en, ccwrite, cctrans & 1'b0}), 32'd0);
            if (dWEN && !dwait) begin
                if (q.size() == 0) begin
                    chk("unexpected_wb_word", daddr, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("wb_kind", 32'(e.is_upd), 32'd0);
                    chk("wb_daddr", daddr, e.addr);
                    chk("wb_dstore", dstore, e.data);
                end
            end
            if (upd_en) begin
                if (q.size() == 0) begin
                    chk("unexpected_upd", 32'(upd_way), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("upd_kind", 32'(e.is_upd), 32'd1);
                    chk("upd_way", 32'(upd_way), 32'(e.way));
                    chk("upd_valid", 32'(upd_valid), 32'(e.valid));
                    chk("upd_dirty", 32'(upd_dirty), 32'd0);
                end
                valid_m[upd_way][snoop_idx] = upd_valid;
                dirty_m[upd_way][snoop_idx] = upd_dirty;
            end
        end
    end

    // Reference model: predicts the outputs one snoop must produce
    task automatic expect_snoop(input logic [31:0] a, input bit inv, output bit miss);
        int               idx;
        logic [TAG_W-1:0] tg;
        int               hw;
        idx = int'(a[5:3]);
        tg  = a[31:6];
        hw  = -1;
        for (int w = 1; w >= 0; w--)
            if (valid_m[w][idx] && tag_m[w][idx] == tg) hw = w;
        miss = (hw < 0);
        if (!miss) begin
            if (dirty_m[hw][idx]) begin
                q.push_back('{0, {a[31:3], 3'b000}, data_m[hw][idx][0], 0, 0});
                q.push_back('{0, {a[31:3], 3'b100}, data_m[hw][idx][1], 0, 0});
                q.push_back('{1, 32'd0, 32'd0, hw[0], !inv});
            end else if (inv) begin
                q.push_back('{1, 32'd0, 32'd0, hw[0], 1'b0});
            end
        end
    endtask

    task automatic run_snoop(input logic [31:0] a, input bit inv, input int busy);
        bit miss;
        int n;
        expect_snoop(a, inv, miss);
        cur_idx     = a[5:3];
        ccsnoopaddr = a;
        ccinv       = inv;
        cache_idle  = (busy == 0);
        ccwait      = 1'b1;
        for (int i = 0; i < busy; i++) begin
            @(posedge CLK); #1;
            chk("busy_hold_idle", 32'(snoop_active), 32'd0);
        end
        cache_idle = 1'b1;
        @(posedge CLK); #1;
        chk("accept_active", 32'(snoop_active), 32'd1);
        chk("accept_cctrans", 32'(cctrans), 32'd1);
        if (miss) begin
            @(posedge CLK); #1;
            chk("miss_to_done_trans", 32'(cctrans), 32'd1);
            @(posedge CLK); #1;
            chk("miss_done_hold", 32'(cctrans), 32'd0);
        end
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        chk("drain_in_time", 32'(n < 300), 32'd1);
        if (n >= 300) q.delete();
        repeat (3) @(posedge CLK);
        #1;
        chk("done_wen_off", 32'(dWEN), 32'd0);
        chk("done_active", 32'(snoop_active), 32'd1);
        chk("done_steady", 32'(cctrans), 32'd0);
        ccwait = 1'b0;
        @(posedge CLK); #1;
        chk("release_idle", 32'(snoop_active), 32'd0);
        chk("release_cctrans", 32'(cctrans), 32'd1);
    endtask

    task automatic rand_frame(input int idx, input logic [TAG_W-1:0] tg);
        for (int w = 0; w < 2; w++) begin
            tag_m[w][idx]   = ($urandom_range(0, 1) == 1) ? tg : (tg ^ TAG_W'($urandom_range(1, 3)));
            valid_m[w][idx] = ($urandom_range(0, 3) != 0);
            dirty_m[w][idx] = ($urandom_range(0, 1) == 1);
            data_m[w][idx][0] = $urandom;
            data_m[w][idx][1] = $urandom;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int               n;
        int               qs;
        logic [TAG_W-1:0] tg;
        int               idx;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
                tag_m[w][s] = '0; valid_m[w][s] = 0; dirty_m[w][s] = 0;
                data_m[w][s][0] = 32'd0; data_m[w][s][1] = 32'd0;
            end
        nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = 32'd0; cache_idle = 1'b1;
        dwait = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 32'({snoop_active, dWEN, ccwrite, upd_en, cctrans}), 32'd0);
        chk("reset_daddr", daddr, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;
        chk("post_reset_idle", 32'(snoop_active), 32'd0);

        // Dirty hit in way 1 with invalidate, two stalls per word
        tag_m[0][1] = 26'd9; valid_m[0][1] = 0; dirty_m[0][1] = 0;
        tag_m[1][1] = 26'd1; valid_m[1][1] = 1; dirty_m[1][1] = 1;
        data_m[1][1][0] = 32'h1111_AAAA; data_m[1][1][1] = 32'h2222_BBBB;
        dwait_mode = 3;
        run_snoop(32'h0000_0048, 1'b1, 0);
        dwait_mode = 0;
        // Clean hit in way 0: no invalidate, then invalidate
        tag_m[0][1] = 26'd1; valid_m[0][1] = 1; dirty_m[0][1] = 0;
        run_snoop(32'h0000_0048, 1'b0, 0);
        run_snoop(32'h0000_0048, 1'b1, 0);
        // Both ways hit: way 0 (clean) wins over dirty way 1
        tag_m[0][4] = 26'd2; valid_m[0][4] = 1; dirty_m[0][4] = 0;
        tag_m[1][4] = 26'd2; valid_m[1][4] = 1; dirty_m[1][4] = 1;
        run_snoop({26'd2, 3'd4, 3'b000}, 1'b1, 0);
        // Miss
        run_snoop({26'd7, 3'd5, 3'b100}, 1'b1, 0);
        // Held off by a busy cache for 5 cycles
        tag_m[1][6] = 26'd3; valid_m[1][6] = 1; dirty_m[1][6] = 0; valid_m[0][6] = 0;
        run_snoop({26'd3, 3'd6, 3'b000}, 1'b1, 5);

        // Abort during WB0: no frame update
        tag_m[0][3] = 26'd7; valid_m[0][3] = 1; dirty_m[0][3] = 1;
        dwait_mode = 2;
        cur_idx = 3'd3; ccsnoopaddr = {26'd7, 3'd3, 3'b000}; ccinv = 1'b1; ccwait = 1'b1;
        n = 0;
        while (!dWEN && n < 20) begin @(posedge CLK); #1; n++; end
        chk("abort_reach_wb", 32'(dWEN), 32'd1);
        ccwait = 1'b0;
        @(posedge CLK); #1;
        chk("abort_idle", 32'({snoop_active, dWEN}), 32'd0);
        chk("abort_no_update", 32'({valid_m[0][3], dirty_m[0][3]}), 32'd3);

        // Reset during WB1
        tag_m[1][2] = 26'd5; valid_m[1][2] = 1; dirty_m[1][2] = 1; valid_m[0][2] = 0;
        data_m[1][2][0] = 32'hCAFE_0000; data_m[1][2][1] = 32'hCAFE_0004;
        dwait_mode = 4;
        begin
            bit miss;
            expect_snoop({26'd5, 3'd2, 3'b000}, 1'b1, miss);
        end
        cur_idx = 3'd2; ccsnoopaddr = {26'd5, 3'd2, 3'b000}; ccinv = 1'b1; ccwait = 1'b1;
        n = 0;
        while (!(dWEN && daddr[2]) && n < 50) begin @(posedge CLK); #1; n++; end
        chk("rst_reach_wb1", 32'(dWEN & daddr[2]), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'({snoop_active, dWEN, ccwrite, upd_en, cctrans}), 32'd0);
        chk("rst_async_daddr", daddr, 32'd0);
        chk("rst_async_dstore", dstore, 32'd0);
        qs = q.size();
        chk("rst_one_word_done", 32'(qs), 32'd2);
        q.delete();
        ccwait = 1'b0; dwait_mode = 0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            chk("post_rst_idle", 32'(snoop_active), 32'd0);
        end
        chk("rst_no_partial_upd", 32'({valid_m[1][2], dirty_m[1][2]}), 32'd3);

        // Randomized snoops
        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 7);
            tg  = TAG_W'($urandom_range(0, 3));
            rand_frame(idx, tg);
            dwait_mode = $urandom_range(0, 1);
            run_snoop({tg, 3'(idx), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))},
                      ($urandom_range(0, 1) == 1), $urandom_range(0, 3));
        end
        dwait_mode = 0;
        repeat (2) @(posedge CLK);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
